// File: rtl/pipe_qr_inst_queue.sv
// Instruction queue at the decode->rename boundary: compacts up to four valid
// bundle slots into a circular buffer and offers the two oldest entries to rename.
module pipe_qr_inst_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ISN_WIDTH     = 99,
  parameter int DEPTH         = 16
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset_n,
  input  logic                       i_Flush,
  input  logic [ADDRESS_WIDTH-1:0]   i_PC,
  input  logic [ISN_WIDTH-1:0]       i_Instruction1,
  input  logic [ISN_WIDTH-1:0]       i_Instruction2,
  input  logic [ISN_WIDTH-1:0]       i_Instruction3,
  input  logic [ISN_WIDTH-1:0]       i_Instruction4,
  input  logic                       i_prediction,
  input  logic [ADDRESS_WIDTH-1:0]   i_branch_target,
  input  logic [1:0]                 i_thread,
  input  logic [3:0]                 i_valid,
  output logic                       o_Stall,
  input  logic [1:0]                 i_deq_count,
  output logic [1:0]                 o_deq_valid,
  output logic [ISN_WIDTH-1:0]       o_deq_isn0,
  output logic [ISN_WIDTH-1:0]       o_deq_isn1,
  output logic [ADDRESS_WIDTH-1:0]   o_deq_pc0,
  output logic [ADDRESS_WIDTH-1:0]   o_deq_pc1,
  output logic [1:0]                 o_deq_thread0,
  output logic [1:0]                 o_deq_thread1,
  output logic                       o_deq_pred0,
  output logic                       o_deq_pred1,
  output logic [ADDRESS_WIDTH-1:0]   o_deq_target0,
  output logic [ADDRESS_WIDTH-1:0]   o_deq_target1,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(DEPTH - 4);

  logic [PTR_W-1:0] head, tail, head_p1;
  logic [CNT_W-1:0] count;

  logic [ISN_WIDTH-1:0]     isn_mem  [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] tgt_mem  [DEPTH];
  logic [1:0]               thr_mem  [DEPTH];
  logic                     pred_mem [DEPTH];

  logic [ISN_WIDTH-1:0]     slot_isn  [4];
  logic [ADDRESS_WIDTH-1:0] slot_pc   [4];
  logic [PTR_W-1:0]         slot_idx  [4];
  logic [3:0]               slot_last;
  logic [2:0]               n_enq;
  logic                     enq_fire;
  logic [1:0]               n_deq;

  // Rename may ask for up to 3 but only two read ports exist, and never more
  // than what is actually stored.
  function automatic logic [1:0] sat_deq(input logic [1:0] req, input logic [CNT_W-1:0] cnt);
    logic [1:0] lim_req, lim_cnt;
    lim_req = (req > 2'd2) ? 2'd2 : req;
    lim_cnt = (cnt >= CNT_W'(2)) ? 2'd2 : cnt[1:0];
    return (lim_req < lim_cnt) ? lim_req : lim_cnt;
  endfunction

  // Stall depends only on registered occupancy so the pipeline register sees no
  // combinational path from its own outputs.
  assign o_Stall  = (count > STALL_LEVEL);
  assign enq_fire = !o_Stall && !i_Flush && (i_valid != 4'b0000);
  assign n_deq    = sat_deq(i_deq_count, count);
  assign o_count  = count;

  assign slot_isn[0] = i_Instruction1;
  assign slot_isn[1] = i_Instruction2;
  assign slot_isn[2] = i_Instruction3;
  assign slot_isn[3] = i_Instruction4;

  // Each valid slot lands at tail plus the number of valid slots below it,
  // which packs the bundle with no holes.
  always_comb begin
    logic [2:0] ofs;
    ofs = 3'd0;
    for (int k = 0; k < 4; k++) begin
      slot_idx[k]  = tail + PTR_W'(ofs);
      slot_pc[k]   = i_PC + ADDRESS_WIDTH'(4 * k);
      slot_last[k] = i_valid[k] && ((i_valid >> (k + 1)) == 4'b0000);
      ofs          = ofs + {2'b00, i_valid[k]};
    end
    n_enq = ofs;
  end

  // ---- stage boundary: pointer / occupancy update ----
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (i_Flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      if (enq_fire)
        tail <= tail + PTR_W'(n_enq);
      count <= count + (enq_fire ? CNT_W'(n_enq) : CNT_W'(0)) - CNT_W'(n_deq);
    end
  end

  // ---- stage boundary: entry storage ----
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        isn_mem[i]  <= '0;
        pc_mem[i]   <= '0;
        tgt_mem[i]  <= '0;
        thr_mem[i]  <= '0;
        pred_mem[i] <= 1'b0;
      end
    end else if (enq_fire) begin
      for (int k = 0; k < 4; k++) begin
        if (i_valid[k]) begin
          isn_mem[slot_idx[k]]  <= slot_isn[k];
          pc_mem[slot_idx[k]]   <= slot_pc[k];
          thr_mem[slot_idx[k]]  <= i_thread;
          // Only the last instruction of the bundle can be the predicted branch.
          pred_mem[slot_idx[k]] <= slot_last[k] & i_prediction;
          tgt_mem[slot_idx[k]]  <= slot_last[k] ? i_branch_target : '0;
        end
      end
    end
  end

  // ---- stage boundary: read ports, empty slots forced to zero ----
  assign head_p1     = head + PTR_W'(1);
  assign o_deq_valid = {count >= CNT_W'(2), count != '0};

  assign o_deq_isn0    = o_deq_valid[0] ? isn_mem[head]  : '0;
  assign o_deq_pc0     = o_deq_valid[0] ? pc_mem[head]   : '0;
  assign o_deq_thread0 = o_deq_valid[0] ? thr_mem[head]  : '0;
  assign o_deq_pred0   = o_deq_valid[0] ? pred_mem[head] : 1'b0;
  assign o_deq_target0 = o_deq_valid[0] ? tgt_mem[head]  : '0;

  assign o_deq_isn1    = o_deq_valid[1] ? isn_mem[head_p1]  : '0;
  assign o_deq_pc1     = o_deq_valid[1] ? pc_mem[head_p1]   : '0;
  assign o_deq_thread1 = o_deq_valid[1] ? thr_mem[head_p1]  : '0;
  assign o_deq_pred1   = o_deq_valid[1] ? pred_mem[head_p1] : 1'b0;
  assign o_deq_target1 = o_deq_valid[1] ? tgt_mem[head_p1]  : '0;

endmodule
